// File: rtl/security_supervisor_pkg.sv
// Shared types for the security supervisor: state encodings and helpers.
// Optional build macro used by this slice: SIREN_CHIRP_EN.
package security_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_SIREN    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    localparam int FC_W = 3;
    localparam int TL_W = 6;

    // Prescaler width; a one-cycle second still needs one bit.
    function automatic int presc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds timer: prescaler producing one tick per second and a
// 6-bit down counter of whole seconds with an expiry strobe.
module sec_timer
    import security_supervisor_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            load,
    input  logic [TL_W-1:0] load_val,
    output logic            tick,
    output logic            expire,
    output logic [TL_W-1:0] time_left
);

    localparam int PW = presc_width(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;

    assign tick   = (presc == '0);
    assign expire = tick && (time_left == TL_W'(1));

    // Load restarts a full second; otherwise count down and tick at zero.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc     <= '0;
            time_left <= '0;
        end else if (load) begin
            presc     <= PRESC_TOP;
            time_left <= load_val;
        end else begin
            if (tick) begin
                presc <= PRESC_TOP;
            end else begin
                presc <= presc - PW'(1);
            end
            if (tick && (time_left != '0)) begin
                time_left <= time_left - TL_W'(1);
            end
        end
    end

endmodule

// File: rtl/security_supervisor.sv
// Turns lock verdicts into timed strike, siren and lockout actions.
// Optional build macro: SIREN_CHIRP_EN (1 s on / 1 s off siren).
module security_supervisor
    import security_supervisor_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_FAILS     = 3,
    parameter int UNLOCK_SECS   = 5,
    parameter int SIREN_SECS    = 10,
    parameter int HOLD_SECS     = 20
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            open,
    input  logic            alarm,
    input  logic            neww,
    output logic            door_unlock,
    output logic            siren,
    output logic            locked_out,
    output logic [FC_W-1:0] fail_count,
    output logic [TL_W-1:0] time_left
);

    localparam logic [FC_W-1:0] MAX_FC  = FC_W'(MAX_FAILS);
    localparam logic [TL_W-1:0] T_UNL   = TL_W'(UNLOCK_SECS);
    localparam logic [TL_W-1:0] T_SIREN = TL_W'(SIREN_SECS);
    localparam logic [TL_W-1:0] T_HOLD  = TL_W'(HOLD_SECS);

    logic [2:0]      in_q;
    logic [2:0]      in_p;
    logic            ev_open;
    logic            ev_alarm;
    logic            ev_neww;
    state_t          state;
    state_t          state_n;
    logic [FC_W-1:0] fail_n;
    logic [FC_W-1:0] base;
    logic            load;
    logic [TL_W-1:0] load_val;
    logic            tick;
    logic            expire;

    assign ev_open  = in_q[2] & ~in_p[2];
    assign ev_alarm = in_q[1] & ~in_p[1];
    assign ev_neww  = in_q[0] & ~in_p[0];

    sec_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_timer (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .expire   (expire),
        .time_left(time_left)
    );

    // Next state, failure count and timer load from the current events.
    always_comb begin
        state_n  = state;
        fail_n   = fail_count;
        base     = ev_neww ? '0 : fail_count;
        load     = 1'b0;
        load_val = '0;
        unique case (state)
            ST_ARMED: begin
                if (ev_alarm) begin
                    if (base + FC_W'(1) >= MAX_FC) begin
                        fail_n   = MAX_FC;
                        state_n  = ST_SIREN;
                        load     = 1'b1;
                        load_val = T_SIREN;
                    end else begin
                        fail_n = base + FC_W'(1);
                    end
                end else if (ev_open) begin
                    fail_n   = '0;
                    state_n  = ST_UNLOCKED;
                    load     = 1'b1;
                    load_val = T_UNL;
                end else if (ev_neww) begin
                    fail_n = '0;
                end
            end
            ST_UNLOCKED: begin
                if (ev_neww) begin
                    fail_n = '0;
                end
                if (ev_open) begin
                    load     = 1'b1;
                    load_val = T_UNL;
                end else if (expire) begin
                    state_n = ST_ARMED;
                end
            end
            ST_SIREN: begin
                if (expire) begin
                    state_n  = ST_HOLDOFF;
                    load     = 1'b1;
                    load_val = T_HOLD;
                end
            end
            ST_HOLDOFF: begin
                if (expire) begin
                    state_n = ST_ARMED;
                    fail_n  = '0;
                end
            end
            default: begin
                state_n = ST_ARMED;
            end
        endcase
    end

`ifdef SIREN_CHIRP_EN
    logic chirp;
    logic chirp_n;

    // Chirp phase restarts high on siren entry and flips every second.
    always_comb begin
        chirp_n = chirp;
        if ((state != ST_SIREN) && (state_n == ST_SIREN)) begin
            chirp_n = 1'b1;
        end else if (tick) begin
            chirp_n = ~chirp;
        end
    end

    // Chirp phase register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            chirp <= 1'b0;
        end else begin
            chirp <= chirp_n;
        end
    end

    // Siren drive gated by the chirp phase.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            siren <= 1'b0;
        end else begin
            siren <= (state_n == ST_SIREN) && chirp_n;
        end
    end
`else
    logic unused_tick;
    assign unused_tick = tick;

    // Siren steady for the whole siren phase.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            siren <= 1'b0;
        end else begin
            siren <= (state_n == ST_SIREN);
        end
    end
`endif

    // Input/edge registers, FSM state, count and Moore output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            in_q        <= '0;
            in_p        <= '0;
            state       <= ST_ARMED;
            fail_count  <= '0;
            door_unlock <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            in_q        <= {open, alarm, neww};
            in_p        <= in_q;
            state       <= state_n;
            fail_count  <= fail_n;
            door_unlock <= (state_n == ST_UNLOCKED);
            locked_out  <= (state_n == ST_SIREN) || (state_n == ST_HOLDOFF);
        end
    end

endmodule

// File: tb/tb_security_supervisor.sv
// Randomised scoreboard bench for security_supervisor.
// Reference model tracks remaining cycles per timed state.
module tb_security_supervisor;

    localparam int TPS  = 4;
    localparam int MAXF = 3;
    localparam int US   = 5;
    localparam int SS   = 10;
    localparam int HS   = 20;

    typedef struct packed {
        logic       door;
        logic       sir;
        logic       lock;
        logic [2:0] fc;
        logic [5:0] tl;
    } obs_t;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       open = 1'b0;
    logic       alarm = 1'b0;
    logic       neww = 1'b0;
    logic       door_unlock;
    logic       siren;
    logic       locked_out;
    logic [2:0] fail_count;
    logic [5:0] time_left;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    obs_t expq[$];

    // Model: 0 armed, 1 unlocked, 2 siren, 3 holdoff
    int   m_st = 0;
    int   m_rem = 0;
    int   m_fails = 0;
    bit [2:0] ms1 = '0;
    bit [2:0] ms2 = '0;

    security_supervisor #(
        .TICKS_PER_SEC(TPS),
        .MAX_FAILS    (MAXF),
        .UNLOCK_SECS  (US),
        .SIREN_SECS   (SS),
        .HOLD_SECS    (HS)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .open       (open),
        .alarm      (alarm),
        .neww       (neww),
        .door_unlock(door_unlock),
        .siren      (siren),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .time_left  (time_left)
    );

    always #5 Clock = ~Clock;

    function automatic obs_t observed();
        obs_t o;
        o.door = door_unlock;
        o.sir  = siren;
        o.lock = locked_out;
        o.fc   = fail_count;
        o.tl   = time_left;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   el;
        o.door = (m_st == 1);
        o.lock = (m_st == 2) || (m_st == 3);
        o.fc   = 3'(m_fails);
        o.tl   = (m_st == 0) ? 6'd0 : 6'((m_rem + TPS - 1) / TPS);
        el     = SS * TPS - m_rem;
`ifdef SIREN_CHIRP_EN
        o.sir  = (m_st == 2) && (((el / TPS) % 2) == 0);
`else
        o.sir  = (m_st == 2) && (el >= 0);
`endif
        return o;
    endfunction

    task automatic model_step(input bit o, input bit a, input bit n);
        bit eo;
        bit ea;
        bit en;
        int b;
        eo = ms1[2] && !ms2[2];
        ea = ms1[1] && !ms2[1];
        en = ms1[0] && !ms2[0];
        b  = en ? 0 : m_fails;
        case (m_st)
            0: begin
                if (ea) begin
                    if (b + 1 >= MAXF) begin
                        m_fails = MAXF;
                        m_st    = 2;
                        m_rem   = SS * TPS;
                    end else begin
                        m_fails = b + 1;
                    end
                end else if (eo) begin
                    m_st    = 1;
                    m_rem   = US * TPS;
                    m_fails = 0;
                end else if (en) begin
                    m_fails = 0;
                end
            end
            1: begin
                if (en) m_fails = 0;
                if (eo) begin
                    m_rem = US * TPS;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_st = 0;
                end
            end
            2: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_st  = 3;
                    m_rem = HS * TPS;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_st    = 0;
                    m_fails = 0;
                end
            end
        endcase
        ms2 = ms1;
        ms1 = {o, a, n};
    endtask

    task automatic drive(input bit o, input bit a, input bit n);
        @(negedge Clock);
        Resetn = 1'b1;
        open   = o;
        alarm  = a;
        neww   = n;
        model_step(o, a, n);
        expq.push_back(model_out());
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0);
    endtask

    task automatic pulse(input bit o, input bit a, input bit n);
        drive(o, a, n);
        drive(0, 0, 0);
    endtask

    task automatic do_reset(input int k);
        obs_t g;
        @(negedge Clock);
        Resetn  = 1'b0;
        m_st    = 0;
        m_rem   = 0;
        m_fails = 0;
        ms1     = '0;
        ms2     = '0;
        #1;
        g = observed();
        tests++;
        if (g !== '0) begin
            fails++;
            $display("FAIL async_reset t=%0t got=%h want=0", $time, g);
        end
        expq.push_back('0);
        for (int i = 1; i < k; i++) begin
            @(negedge Clock);
            expq.push_back('0);
        end
    endtask

    // Monitor: compare every clock's outputs against the scoreboard head.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge Clock);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                g = observed();
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got door=%0b sir=%0b lock=%0b fc=%0d tl=%0d want door=%0b sir=%0b lock=%0b fc=%0d tl=%0d",
                             cyc, g.door, g.sir, g.lock, g.fc, g.tl,
                             e.door, e.sir, e.lock, e.fc, e.tl);
                end
            end
        end
    end

    // Stimulus: directed scenarios then biased random traffic.
    initial begin
        do_reset(3);
        idle(2);
        pulse(1, 0, 0);
        idle(25);
        repeat (3) pulse(0, 1, 0);
        idle(170);
        repeat (2) pulse(0, 1, 0);
        pulse(0, 0, 1);
        repeat (2) pulse(0, 1, 0);
        idle(5);
        pulse(0, 1, 0);
        idle(45);
        pulse(1, 0, 0);
        idle(90);
        pulse(1, 1, 0);
        idle(5);
        pulse(1, 0, 0);
        idle(12);
        pulse(1, 0, 0);
        idle(25);
        repeat (2) pulse(0, 1, 0);
        idle(10);
        open = 1'b1;
        do_reset(2);
        drive(1, 0, 0);
        idle(30);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                drive($urandom_range(0, 11) == 0,
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 15) == 0);
            end
        end
        idle(3);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge Clock);
        #2;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending want=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
